// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: writeback-select and branch-op encodings,
// the packed decode control bundle, its bubble value and the load-use
// interlock state type.
package rv_pipe_pkg;

   localparam logic [1:0] RF_SEL_MEM = 2'b00;
   localparam logic [1:0] RF_SEL_ALU = 2'b01;
   localparam logic [1:0] RF_SEL_PC4 = 2'b11;

   localparam logic [4:0] BR_NONE = 5'b00000;
   localparam logic [4:0] BR_JUMP = 5'b11111;

   typedef struct packed {
      logic       type_alu;
      logic       store;
      logic       control_alu;
      logic       control_op1;
      logic       we;
      logic [2:0] type_dm;
      logic [2:0] funct3;
      logic [2:0] funct_imm;
      logic [1:0] control_rf;
      logic [4:0] brop;
   } ctrl_bundle_t;

   // A bubble never writes the RF, never stores and never branches; the
   // remaining fields are irrelevant and kept at zero.
   localparam ctrl_bundle_t CTRL_BUBBLE = '{
      type_alu:    1'b0,
      store:       1'b0,
      control_alu: 1'b0,
      control_op1: 1'b0,
      we:          1'b0,
      type_dm:     3'b000,
      funct3:      3'b000,
      funct_imm:   3'b000,
      control_rf:  RF_SEL_MEM,
      brop:        BR_NONE
   };

   typedef enum logic {
      LU_NORMAL  = 1'b0,
      LU_BUBBLED = 1'b1
   } lu_state_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use comparator between the
// instruction held in EX and the one waiting in decode. rs2 is compared
// even for formats without an rs2 field; the rare extra stall is accepted.
module load_use_detect
   import rv_pipe_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              id_valid,
   input  logic              ex_valid,
   input  logic              ex_we,
   input  logic [1:0]        ex_control_rf,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   output logic              hazard
);

   logic ex_is_load;
   logic rd_match;

   // EX holds a load whose destination is a real register that decode reads.
   always_comb begin
      ex_is_load = ex_valid && ex_we && (ex_control_rf == RF_SEL_MEM);
      rd_match   = (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
      hazard     = id_valid && ex_is_load && rd_match;
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the RV32I pipeline.
// Action priority each cycle: reset > hold > flush > load-use bubble > load.
// Build option: ID_EX_HAZARD_DETECT_EN enables the load-use interlock
// (comparator + NORMAL/BUBBLED FSM). Without it stall_o simply follows
// hold_i and load-use separation is left to the toolchain.
// Handshake: there is no valid/ready pair here; ex_valid_o qualifies the EX
// slot, stall_o tells IF/ID to re-present the same decode slot next cycle,
// and hold_i freezes every register in this stage.
module id_ex_stage
   import rv_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid_i,
   input  logic              id_type_alu_i,
   input  logic              id_store_i,
   input  logic              id_control_alu_i,
   input  logic              id_control_op1_i,
   input  logic              id_we_i,
   input  logic [2:0]        id_type_dm_i,
   input  logic [2:0]        id_funct3_i,
   input  logic [2:0]        id_funct_imm_i,
   input  logic [1:0]        id_control_rf_i,
   input  logic [4:0]        id_brop_i,
   input  logic [XLEN-1:0]   id_pc_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              flush_i,
   input  logic              hold_i,
   output logic              ex_valid_o,
   output logic              ex_type_alu_o,
   output logic              ex_store_o,
   output logic              ex_control_alu_o,
   output logic              ex_control_op1_o,
   output logic              ex_we_o,
   output logic [2:0]        ex_type_dm_o,
   output logic [2:0]        ex_funct3_o,
   output logic [2:0]        ex_funct_imm_o,
   output logic [1:0]        ex_control_rf_o,
   output logic [4:0]        ex_brop_o,
   output logic [XLEN-1:0]   ex_pc_o,
   output logic [XLEN-1:0]   ex_rs1_data_o,
   output logic [XLEN-1:0]   ex_rs2_data_o,
   output logic [XLEN-1:0]   ex_imm_o,
   output logic [REG_AW-1:0] ex_rs1_o,
   output logic [REG_AW-1:0] ex_rs2_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic              stall_o,
   output logic              lu_state_o
);

   ctrl_bundle_t      id_ctrl;
   ctrl_bundle_t      ex_ctrl;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
   logic              hazard;

   assign id_ctrl = '{
      type_alu:    id_type_alu_i,
      store:       id_store_i,
      control_alu: id_control_alu_i,
      control_op1: id_control_op1_i,
      we:          id_we_i,
      type_dm:     id_type_dm_i,
      funct3:      id_funct3_i,
      funct_imm:   id_funct_imm_i,
      control_rf:  id_control_rf_i,
      brop:        id_brop_i
   };

`ifdef ID_EX_HAZARD_DETECT_EN
   lu_state_t state_q, state_d;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
      .id_valid      (id_valid_i),
      .ex_valid      (ex_valid),
      .ex_we         (ex_ctrl.we),
      .ex_control_rf (ex_ctrl.control_rf),
      .ex_rd         (ex_rd),
      .id_rs1        (id_rs1_i),
      .id_rs2        (id_rs2_i),
      .hazard        (hazard)
   );

   // Interlock state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= LU_NORMAL;
      else        state_q <= state_d;
   end

   // Next interlock state: a bubble marks BUBBLED, any other non-hold
   // action (flush or load) returns to NORMAL.
   always_comb begin
      state_d = state_q;
      if (!hold_i) begin
         if (flush_i)     state_d = LU_NORMAL;
         else if (hazard) state_d = LU_BUBBLED;
         else             state_d = LU_NORMAL;
      end
   end

   assign lu_state_o = state_q;
   // A flushed decode slot is being discarded, so there is nothing to stall.
   assign stall_o    = hold_i | (hazard & ~flush_i);
`else
   assign hazard     = 1'b0;
   assign lu_state_o = 1'b0;
   assign stall_o    = hold_i;
`endif

   // Pipeline register: hold keeps, flush/hazard load a bubble, otherwise
   // capture; invalid slots carry bubble control so they never commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= CTRL_BUBBLE;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
      end else if (!hold_i) begin
         if (flush_i || hazard) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_BUBBLE;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
         end else begin
            ex_valid    <= id_valid_i;
            ex_ctrl     <= id_valid_i ? id_ctrl : CTRL_BUBBLE;
            ex_pc       <= id_pc_i;
            ex_rs1_data <= id_rs1_data_i;
            ex_rs2_data <= id_rs2_data_i;
            ex_imm      <= id_imm_i;
            ex_rs1      <= id_rs1_i;
            ex_rs2      <= id_rs2_i;
            ex_rd       <= id_rd_i;
         end
      end
   end

   assign ex_valid_o       = ex_valid;
   assign ex_type_alu_o    = ex_ctrl.type_alu;
   assign ex_store_o       = ex_ctrl.store;
   assign ex_control_alu_o = ex_ctrl.control_alu;
   assign ex_control_op1_o = ex_ctrl.control_op1;
   assign ex_we_o          = ex_ctrl.we;
   assign ex_type_dm_o     = ex_ctrl.type_dm;
   assign ex_funct3_o      = ex_ctrl.funct3;
   assign ex_funct_imm_o   = ex_ctrl.funct_imm;
   assign ex_control_rf_o  = ex_ctrl.control_rf;
   assign ex_brop_o        = ex_ctrl.brop;
   assign ex_pc_o          = ex_pc;
   assign ex_rs1_data_o    = ex_rs1_data;
   assign ex_rs2_data_o    = ex_rs2_data;
   assign ex_imm_o         = ex_imm;
   assign ex_rs1_o         = ex_rs1;
   assign ex_rs2_o         = ex_rs2;
   assign ex_rd_o          = ex_rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios followed by randomized traffic,
// checked against a slot-level reference model of the ID/EX register.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic        type_alu;
      logic        store;
      logic        control_alu;
      logic        control_op1;
      logic        we;
      logic [2:0]  type_dm;
      logic [2:0]  funct3;
      logic [2:0]  funct_imm;
      logic [1:0]  control_rf;
      logic [4:0]  brop;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } slot_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   slot_t id_s;
   logic  flush, hold;

   logic        ex_valid_o, ex_type_alu_o, ex_store_o, ex_control_alu_o;
   logic        ex_control_op1_o, ex_we_o;
   logic [2:0]  ex_type_dm_o, ex_funct3_o, ex_funct_imm_o;
   logic [1:0]  ex_control_rf_o;
   logic [4:0]  ex_brop_o;
   logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
   logic        stall_o, lu_state_o;

   id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .id_valid_i       (id_s.valid),
      .id_type_alu_i    (id_s.type_alu),
      .id_store_i       (id_s.store),
      .id_control_alu_i (id_s.control_alu),
      .id_control_op1_i (id_s.control_op1),
      .id_we_i          (id_s.we),
      .id_type_dm_i     (id_s.type_dm),
      .id_funct3_i      (id_s.funct3),
      .id_funct_imm_i   (id_s.funct_imm),
      .id_control_rf_i  (id_s.control_rf),
      .id_brop_i        (id_s.brop),
      .id_pc_i          (id_s.pc),
      .id_rs1_data_i    (id_s.rs1_data),
      .id_rs2_data_i    (id_s.rs2_data),
      .id_imm_i         (id_s.imm),
      .id_rs1_i         (id_s.rs1),
      .id_rs2_i         (id_s.rs2),
      .id_rd_i          (id_s.rd),
      .flush_i          (flush),
      .hold_i           (hold),
      .ex_valid_o       (ex_valid_o),
      .ex_type_alu_o    (ex_type_alu_o),
      .ex_store_o       (ex_store_o),
      .ex_control_alu_o (ex_control_alu_o),
      .ex_control_op1_o (ex_control_op1_o),
      .ex_we_o          (ex_we_o),
      .ex_type_dm_o     (ex_type_dm_o),
      .ex_funct3_o      (ex_funct3_o),
      .ex_funct_imm_o   (ex_funct_imm_o),
      .ex_control_rf_o  (ex_control_rf_o),
      .ex_brop_o        (ex_brop_o),
      .ex_pc_o          (ex_pc_o),
      .ex_rs1_data_o    (ex_rs1_data_o),
      .ex_rs2_data_o    (ex_rs2_data_o),
      .ex_imm_o         (ex_imm_o),
      .ex_rs1_o         (ex_rs1_o),
      .ex_rs2_o         (ex_rs2_o),
      .ex_rd_o          (ex_rd_o),
      .stall_o          (stall_o),
      .lu_state_o       (lu_state_o)
   );

   // ---------------- scoreboard / model ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   slot_t       m;            // what the EX slot should hold
   logic        m_bubbled;    // last action was a load-use bubble
   logic        captured_new;
   logic [31:0] exp_q[$];     // PCs of valid instructions expected in EX

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // A valid load in EX writing a nonzero register that decode reads.
   function automatic logic model_hazard();
`ifdef ID_EX_HAZARD_DETECT_EN
      return id_s.valid && m.valid && m.we && (m.control_rf == 2'b00) &&
             (m.rd != 5'd0) && ((m.rd == id_s.rs1) || (m.rd == id_s.rs2));
`else
      return 1'b0;
`endif
   endfunction

   function automatic slot_t random_slot();
      slot_t s;
      s.valid       = 1'b1;
      s.type_alu    = 1'($urandom_range(0, 1));
      s.store       = 1'($urandom_range(0, 1));
      s.control_alu = 1'($urandom_range(0, 1));
      s.control_op1 = 1'($urandom_range(0, 1));
      s.we          = 1'($urandom_range(0, 1));
      s.type_dm     = 3'($urandom_range(0, 7));
      s.funct3      = 3'($urandom_range(0, 7));
      s.funct_imm   = 3'($urandom_range(0, 7));
      s.control_rf  = 2'($urandom_range(0, 3));
      s.brop        = 5'($urandom_range(0, 31));
      s.pc          = $urandom;
      s.rs1_data    = $urandom;
      s.rs2_data    = $urandom;
      s.imm         = $urandom;
      s.rs1         = 5'($urandom_range(0, 3));
      s.rs2         = 5'($urandom_range(0, 3));
      s.rd          = 5'($urandom_range(0, 3));
      return s;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_instr(input logic [31:0] pc, input logic we, input logic [1:0] rf,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      id_s            = random_slot();
      id_s.pc         = pc;
      id_s.we         = we;
      id_s.control_rf = rf;
      id_s.rd         = rd;
      id_s.rs1        = rs1;
      id_s.rs2        = rs2;
      id_s.store      = 1'b0;
      id_s.brop       = 5'd0;
   endtask

   // One clock: check stall before the edge, advance the model at the
   // edge, then check every EX output.
   task automatic cycle();
      logic hz;
      #1;
      hz = model_hazard();
      check("stall", 32'(stall_o), 32'(hold | (hz & ~flush)));
      @(posedge clk);
      captured_new = 1'b0;
      if (!rst_n) begin
         m = '0; m_bubbled = 1'b0;
      end else if (hold) begin
         // everything keeps its value
      end else if (flush) begin
         m = '0; m_bubbled = 1'b0;
      end else if (hz) begin
         m = '0; m_bubbled = 1'b1;
      end else begin
         m = id_s; m_bubbled = 1'b0;
         if (!id_s.valid) begin
            m.type_alu = 0; m.store = 0; m.control_alu = 0; m.control_op1 = 0;
            m.we = 0; m.type_dm = 0; m.funct3 = 0; m.funct_imm = 0;
            m.control_rf = 0; m.brop = 0;
         end
         captured_new = id_s.valid;
      end
      if (captured_new) exp_q.push_back(id_s.pc);
      #1;
      check("valid",       32'(ex_valid_o),       32'(m.valid));
      check("type_alu",    32'(ex_type_alu_o),    32'(m.type_alu));
      check("store",       32'(ex_store_o),       32'(m.store));
      check("control_alu", 32'(ex_control_alu_o), 32'(m.control_alu));
      check("control_op1", 32'(ex_control_op1_o), 32'(m.control_op1));
      check("we",          32'(ex_we_o),          32'(m.we));
      check("type_dm",     32'(ex_type_dm_o),     32'(m.type_dm));
      check("funct3",      32'(ex_funct3_o),      32'(m.funct3));
      check("funct_imm",   32'(ex_funct_imm_o),   32'(m.funct_imm));
      check("control_rf",  32'(ex_control_rf_o),  32'(m.control_rf));
      check("brop",        32'(ex_brop_o),        32'(m.brop));
      check("pc",          ex_pc_o,               m.pc);
      check("rs1_data",    ex_rs1_data_o,         m.rs1_data);
      check("rs2_data",    ex_rs2_data_o,         m.rs2_data);
      check("imm",         ex_imm_o,              m.imm);
      check("rs1",         32'(ex_rs1_o),         32'(m.rs1));
      check("rs2",         32'(ex_rs2_o),         32'(m.rs2));
      check("rd",          32'(ex_rd_o),          32'(m.rd));
      check("lu_state",    32'(lu_state_o),       32'(m_bubbled));
      if (captured_new && exp_q.size() > 0) check("q_pc", ex_pc_o, exp_q.pop_front());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
      id_s  = random_slot();
      m     = random_slot(); m_bubbled = 1'b1;
      cycle(); cycle();
      rst_n = 1'b1;
      check("rst_valid", 32'(ex_valid_o), 32'd0);
      check("rst_pc", ex_pc_o, 32'd0);

      // add x3,x1,x2 at 0x100
      set_instr(32'h100, 1'b1, 2'b01, 5'd3, 5'd1, 5'd2);
      cycle();
      check("add_pc", ex_pc_o, 32'h100);
      check("add_valid", 32'(ex_valid_o), 32'd1);

      // lw x5 then add x6,x5,x1: one bubble, then the add
      set_instr(32'h104, 1'b1, 2'b00, 5'd5, 5'd1, 5'd0);
      cycle();
      set_instr(32'h108, 1'b1, 2'b01, 5'd6, 5'd5, 5'd1);
      cycle();
      cycle();
      check("dep_rd", 32'(ex_rd_o), 32'd6);

      // lw x0, then a reader of x0: never a hazard
      set_instr(32'h10c, 1'b1, 2'b00, 5'd0, 5'd2, 5'd0);
      cycle();
      set_instr(32'h110, 1'b1, 2'b01, 5'd7, 5'd0, 5'd0);
      cycle();
      check("x0_pc", ex_pc_o, 32'h110);

      // lw x7, then a dependent add with flush: flush wins
      set_instr(32'h114, 1'b1, 2'b00, 5'd7, 5'd1, 5'd1);
      cycle();
      set_instr(32'h118, 1'b1, 2'b01, 5'd8, 5'd7, 5'd1);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      check("flush_valid", 32'(ex_valid_o), 32'd0);

      // hold for three cycles mid-stream, then resume
      set_instr(32'h200, 1'b1, 2'b01, 5'd9, 5'd1, 5'd2);
      cycle();
      set_instr(32'h204, 1'b1, 2'b01, 5'd10, 5'd3, 5'd4);
      hold = 1'b1;
      repeat (3) cycle();
      hold = 1'b0;
      cycle();
      check("hold_resume_pc", ex_pc_o, 32'h204);

      // reset in the middle of a load-use stall
      set_instr(32'h300, 1'b1, 2'b00, 5'd2, 5'd1, 5'd1);
      cycle();
      set_instr(32'h304, 1'b1, 2'b01, 5'd3, 5'd2, 5'd1);
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         id_s       = random_slot();
         id_s.valid = ($urandom_range(0, 7) != 0);
         flush      = ($urandom_range(0, 7) == 0);
         hold       = ($urandom_range(0, 7) == 0);
         rst_n      = ($urandom_range(0, 49) != 0);
         cycle();
      end
      rst_n = 1'b1; hold = 1'b0; flush = 1'b0;

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
